// File: rtl/mm_sequencer.sv
// mm_sequencer: control sequencer for a serial-input N x M by M x N matrix
// multiplier datapath. It takes a start pulse, then steps through operand
// load, per-result clear / multiply-accumulate / write-back, result
// streaming and a one-cycle completion pulse. No data passes through here.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request a job (accepted only in IDLE)
//   ovf_in            accumulator overflow flag (observed in MAC cycles only)
//   ld_en/ld_sel/ld_addr  operand load strobe, matrix select (0=A,1=B), address
//   a_addr/b_addr     operand read addresses for the current MAC step
//   acc_clr/acc_en    accumulator clear / accumulate strobes
//   c_we/c_addr       result write strobe and result address
//   out_valid         result C[c_addr] is on the datapath output this cycle
//   busy/done         not-idle flag, one-cycle completion pulse
//   overflow          sticky overflow for the current/last job
module mm_sequencer #(
  parameter int N  = 2,
  parameter int M  = 2,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ovf_in,
  output logic          ld_en,
  output logic          ld_sel,
  output logic [AW-1:0] ld_addr,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          c_we,
  output logic [AW-1:0] c_addr,
  output logic          out_valid,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, CLR, MAC, WB, OUT, DONE
  } state_t;

  localparam logic [AW-1:0] LD_LAST  = AW'(N * M - 1);
  localparam logic [AW-1:0] OUT_LAST = AW'(N * N - 1);
  localparam logic [AW-1:0] IJ_LAST  = AW'(N - 1);
  localparam logic [AW-1:0] K_LAST   = AW'(M - 1);

  state_t        state, state_nx;
  logic [AW-1:0] cnt;   // shared by load and output phases
  logic [AW-1:0] i, j, k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Outputs are decoded purely from registered state and counters.
  always_comb begin
    state_nx  = state;
    ld_en     = 1'b0;
    ld_sel    = 1'b0;
    ld_addr   = '0;
    a_addr    = '0;
    b_addr    = '0;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    c_we      = 1'b0;
    c_addr    = '0;
    out_valid = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (start) state_nx = LOAD_A;
      LOAD_A: begin
        ld_en   = 1'b1;
        ld_addr = cnt;
        if (cnt == LD_LAST) state_nx = LOAD_B;
      end
      LOAD_B: begin
        ld_en   = 1'b1;
        ld_sel  = 1'b1;
        ld_addr = cnt;
        if (cnt == LD_LAST) state_nx = CLR;
      end
      CLR: begin
        acc_clr  = 1'b1;
        state_nx = MAC;
      end
      MAC: begin
        acc_en = 1'b1;
        a_addr = i * AW'(M) + k;
        b_addr = k * AW'(N) + j;
        if (k == K_LAST) state_nx = WB;
      end
      WB: begin
        c_we   = 1'b1;
        c_addr = i * AW'(N) + j;
        if (i == IJ_LAST && j == IJ_LAST) state_nx = OUT;
        else                              state_nx = CLR;
      end
      OUT: begin
        out_valid = 1'b1;
        c_addr    = cnt;
        if (cnt == OUT_LAST) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      i   <= '0;
      j   <= '0;
      k   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt <= '0;
          i   <= '0;
          j   <= '0;
          k   <= '0;
        end
        LOAD_A: cnt <= (cnt == LD_LAST) ? '0 : cnt + 1'b1;
        LOAD_B: begin
          cnt <= (cnt == LD_LAST) ? '0 : cnt + 1'b1;
          if (cnt == LD_LAST) begin
            i <= '0;
            j <= '0;
          end
        end
        CLR: k <= '0;
        MAC: if (k != K_LAST) k <= k + 1'b1;
        WB: begin
          if (j != IJ_LAST) begin
            j <= j + 1'b1;
          end else if (i != IJ_LAST) begin
            j <= '0;
            i <= i + 1'b1;
          end
        end
        OUT: cnt <= (cnt == OUT_LAST) ? '0 : cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       overflow <= 1'b0;
    else if (state == IDLE && start) overflow <= 1'b0;
    else if (state == MAC && ovf_in) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_mm_sequencer.sv
// Directed bench for mm_sequencer with N=M=2: per-cycle expected output
// table for a full job, a small behavioural datapath for end-to-end results,
// overflow, held-start and mid-job reset scenarios.
module tb_mm_sequencer;
  localparam int N = 2, M = 2, AW = 4;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, ovf_in = 1'b0;
  logic          ld_en, ld_sel, acc_clr, acc_en, c_we, out_valid, busy, done, overflow;
  logic [AW-1:0] ld_addr, a_addr, b_addr, c_addr;

  mm_sequencer #(.N(N), .M(M), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .ovf_in(ovf_in),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .a_addr(a_addr), .b_addr(b_addr),
    .acc_clr(acc_clr), .acc_en(acc_en),
    .c_we(c_we), .c_addr(c_addr), .out_valid(out_valid),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fails   = 0;
  int done_cnt  = 0;
  int cyc       = 0;
  bit ovf_exp   = 1'b0;

  // A = [2 5;1 3], B = [1 4;2 2] row-major; C = A*B = [12 18;7 10]
  logic [7:0]  stream [8] = '{8'd2, 8'd5, 8'd1, 8'd3, 8'd1, 8'd4, 8'd2, 8'd2};
  logic [15:0] c_exp  [4] = '{16'd12, 16'd18, 16'd7, 16'd10};

  // Behavioural datapath driven by the sequencer strobes
  logic [7:0]  din = 8'd0;
  logic [7:0]  amem [16];
  logic [7:0]  bmem [16];
  logic [15:0] cmem [16];
  logic [15:0] acc;

  always @(posedge clk) begin
    if (ld_en) begin
      if (ld_sel) bmem[ld_addr] <= din;
      else        amem[ld_addr] <= din;
    end
    if (acc_clr)     acc <= 16'd0;
    else if (acc_en) acc <= acc + amem[a_addr] * bmem[b_addr];
    if (c_we) cmem[c_addr] <= acc;
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [24:0] pack_obs();
    return {ld_en, ld_sel, ld_addr, a_addr, b_addr, acc_clr, acc_en, c_we,
            c_addr, out_valid, busy, done, overflow};
  endfunction

  function automatic logic [24:0] mk(bit le, bit ls, logic [3:0] la, logic [3:0] aa,
                                     logic [3:0] ba, bit clr, bit en, bit we,
                                     logic [3:0] ca, bit ov_v, bit bsy, bit dn, bit ov);
    return {le, ls, la, aa, ba, clr, en, we, ca, ov_v, bsy, dn, ov};
  endfunction

  function automatic logic [24:0] mac(logic [3:0] aa, logic [3:0] ba, bit ov);
    return mk(0, 0, 4'd0, aa, ba, 0, 1, 0, 4'd0, 0, 1, 0, ov);
  endfunction

  // Hand-written expected outputs for cycle c of a job (cycle 1 follows the
  // edge that accepts start; cycle 30 is IDLE again).
  function automatic logic [24:0] exp_vec(int c, bit ov);
    case (c)
      1, 2, 3, 4:     return mk(1, 0, 4'(c - 1), 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, ov);
      5, 6, 7, 8:     return mk(1, 1, 4'(c - 5), 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 0, ov);
      9, 13, 17, 21:  return mk(0, 0, 4'd0, 4'd0, 4'd0, 1, 0, 0, 4'd0, 0, 1, 0, ov);
      10:             return mac(4'd0, 4'd0, ov);
      11:             return mac(4'd1, 4'd2, ov);
      14:             return mac(4'd0, 4'd1, ov);
      15:             return mac(4'd1, 4'd3, ov);
      18:             return mac(4'd2, 4'd0, ov);
      19:             return mac(4'd3, 4'd2, ov);
      22:             return mac(4'd2, 4'd1, ov);
      23:             return mac(4'd3, 4'd3, ov);
      12:             return mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 4'd0, 0, 1, 0, ov);
      16:             return mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 4'd1, 0, 1, 0, ov);
      20:             return mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 4'd2, 0, 1, 0, ov);
      24:             return mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 1, 4'd3, 0, 1, 0, ov);
      25, 26, 27, 28: return mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 4'(c - 25), 1, 1, 0, ov);
      29:             return mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 1, 1, ov);
      default:        return mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, ov);
    endcase
  endfunction

  function automatic bit is_mac(int c);
    return c == 10 || c == 11 || c == 14 || c == 15 ||
           c == 18 || c == 19 || c == 22 || c == 23;
  endfunction

  task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int t = 0; t < n; t++) begin
      check("idle", pack_obs(), mk(0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0, 0, ovf_exp));
      @(posedge clk); #1;
    end
  endtask

  // Start a job at the next edge and follow it to cycle 30 (IDLE).
  // ovf_c: cycle in which ovf_in is raised; abort_c: cycle in which rst hits.
  task automatic run_job(input int ovf_c, input bit hold, input int abort_c);
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    ovf_exp = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      cyc = c;
      check("seq", pack_obs(), exp_vec(c, ovf_exp));
      if (c >= 25 && c <= 28) begin
        n_asserts++;
        assert (cmem[c_addr] === c_exp[c - 25]) else begin
          n_fails++;
          $error("FAIL result C%0d: observed %0d expected %0d", c - 25, cmem[c_addr], c_exp[c - 25]);
        end
      end
      if (c == abort_c) begin
        #2 rst = 1'b1;
        #1 check("rst_midjob", pack_obs(), 25'd0);
        @(posedge clk); #1;
        check("rst_held", pack_obs(), 25'd0);
        rst = 1'b0;
        ovf_exp = 1'b0;
        return;
      end
      if (c == 30) break;
      if (c <= 8) din = stream[c - 1];
      ovf_in = (c == ovf_c);
      @(posedge clk); #1;
      if (ovf_in && is_mac(c)) ovf_exp = 1'b1;
      ovf_in = 1'b0;
    end
  endtask

  int d0;

  initial begin
    // Asynchronous reset before the first clock edge
    #2 rst = 1'b1;
    #1 check("rst_async", pack_obs(), 25'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(10);
    check_int("no_done_idle", done_cnt, 0);

    // Nominal job with end-to-end results
    run_job(0, 1'b0, 0);
    check_int("done_nominal", done_cnt, 1);

    // Overflow during the 2nd MAC of C2, sticky through DONE/IDLE
    run_job(19, 1'b0, 0);
    idle_cycles(3);

    // start held high for 70 cycles: exactly two done pulses, overflow cleared
    d0 = done_cnt;
    run_job(0, 1'b1, 0);
    run_job(0, 1'b1, 0);
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_int("done_held", done_cnt - d0, 2);
    #2 rst = 1'b1;
    #1 check("rst_cleanup", pack_obs(), 25'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);

    // Reset during MAC of C1 (overflow already set), then a fresh full job
    d0 = done_cnt;
    run_job(10, 1'b0, 14);
    idle_cycles(3);
    check_int("done_aborted", done_cnt - d0, 0);
    run_job(0, 1'b0, 0);
    check_int("done_after_abort", done_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
